// File: rtl/bus_arbiter_pkg.sv
// Shared encodings, bus payload type and round-robin helper for the external bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned ADR_W  = 64;
  localparam int unsigned DAT_W  = 16;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SZ_NONE = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'b10;
  localparam logic [SIZE_W-1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_F    = 2'b01;
  localparam logic [1:0] OWN_L    = 2'b10;

  // FSM states share the owner encoding so the grant is the state itself
  localparam logic [1:0] ST_IDLE  = OWN_NONE;
  localparam logic [1:0] ST_OWN_F = OWN_F;
  localparam logic [1:0] ST_OWN_L = OWN_L;

  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic [SIZE_W-1:0] size;
    logic              we;
    logic [DAT_W-1:0]  dat;
  } bus_req_t;

  // On a tie the requester that did not own the bus last wins
  function automatic logic [1:0] arbitrate(input logic f_req, input logic l_req,
                                           input logic last_l);
    if (f_req && l_req) return last_l ? OWN_F : OWN_L;
    if (l_req) return OWN_L;
    if (f_req) return OWN_F;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Counts consecutive non-acked owned cycles and pulses err when the limit is reached.
module bus_watchdog #(
  parameter int unsigned TO_W     = 8,
  parameter int unsigned TO_LIMIT = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic active,
  input  logic ack,
  input  logic clear,
  output logic err
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TO_LIMIT);

  logic [TO_W-1:0] wd;
  logic            hit;

  // A limit of zero disables the watchdog entirely
  assign hit = (TO_LIMIT != 0) && active && (wd == LIMIT);
  assign err = hit && !ack;

  // Clearing on hit keeps the counter from ever running past the limit
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd <= '0;
    end else if (!active || clear || ack || hit || (TO_LIMIT == 0)) begin
      wd <= '0;
    end else begin
      wd <= wd + TO_W'(1);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester external bus arbiter: round-robin on ties, atomic hold while size
// is nonzero, zero-turnaround handoff and a per-owner timeout watchdog.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TO_W     = 8,
  parameter int unsigned TO_LIMIT = 255
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [ADR_W-1:0]   f_adr_i,
  input  logic [SIZE_W-1:0]  f_size_i,
  output logic               f_ack_o,
  output logic               f_err_o,
  input  logic [ADR_W-1:0]   l_adr_i,
  input  logic [SIZE_W-1:0]  l_size_i,
  input  logic               l_we_i,
  input  logic [DAT_W-1:0]   l_dat_i,
  output logic               l_ack_o,
  output logic               l_err_o,
  output logic [ADR_W-1:0]   adr_o,
  output logic [SIZE_W-1:0]  size_o,
  output logic               we_o,
  output logic [DAT_W-1:0]   dat_o,
  input  logic               ack_i,
  output logic [1:0]         gnt_o
);

  logic [1:0] state, state_nxt;
  logic       last_l, last_l_nxt;
  logic       f_req, l_req;
  logic       releasing;
  logic       owned;
  logic       illegal;
  logic       wd_err;
  bus_req_t   sel;

  assign f_req = (f_size_i != SZ_NONE);
  assign l_req = (l_size_i != SZ_NONE);
  assign owned = (state != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= ST_IDLE;
      last_l <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_l <= last_l_nxt;
    end
  end

  // Arbitrate from IDLE or at release; otherwise the owner keeps the bus
  always_comb begin
    state_nxt  = state;
    last_l_nxt = last_l;
    releasing  = 1'b0;
    case (state)
      ST_IDLE: state_nxt = arbitrate(f_req, l_req, last_l);
      ST_OWN_F: begin
        if (!f_req) begin
          releasing  = 1'b1;
          last_l_nxt = 1'b0;
          state_nxt  = arbitrate(1'b0, l_req, 1'b0);
        end
      end
      ST_OWN_L: begin
        if (!l_req) begin
          releasing  = 1'b1;
          last_l_nxt = 1'b1;
          state_nxt  = arbitrate(f_req, 1'b0, 1'b1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  bus_watchdog #(
    .TO_W     (TO_W),
    .TO_LIMIT (TO_LIMIT)
  ) u_watchdog (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .active  (owned),
    .ack     (ack_i),
    .clear   (releasing),
    .err     (wd_err)
  );

  // Route the owner's cycle out and the external ack back; reset forces all quiet
  always_comb begin
    sel     = '0;
    adr_o   = '0;
    size_o  = SZ_NONE;
    we_o    = 1'b0;
    dat_o   = '0;
    f_ack_o = 1'b0;
    l_ack_o = 1'b0;
    f_err_o = 1'b0;
    l_err_o = 1'b0;
    gnt_o   = OWN_NONE;
    case (state)
      ST_OWN_F: sel = '{adr: f_adr_i, size: f_size_i, we: 1'b0, dat: DAT_W'(0)};
      ST_OWN_L: sel = '{adr: l_adr_i, size: l_size_i, we: l_we_i, dat: l_dat_i};
      default:  sel = '0;
    endcase
    illegal = (sel.size == SZ_ILL);
    if (!reset_i) begin
      adr_o   = sel.adr;
      size_o  = illegal ? SZ_NONE : sel.size;
      we_o    = sel.we;
      dat_o   = sel.dat;
      f_ack_o = (state == ST_OWN_F) && ack_i && !illegal;
      l_ack_o = (state == ST_OWN_L) && ack_i && !illegal;
      f_err_o = (state == ST_OWN_F) && wd_err;
      l_err_o = (state == ST_OWN_L) && wd_err;
      gnt_o   = state;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic against a
// cycle-level ownership/timeout reference model.
module tb_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [63:0] f_adr_i, l_adr_i, adr_o;
  logic [1:0]  f_size_i, l_size_i, size_o, gnt_o;
  logic        l_we_i, we_o, ack_i;
  logic [15:0] l_dat_i, dat_o;
  logic        f_ack_o, f_err_o, l_ack_o, l_err_o;

  int checks = 0;
  int errors = 0;

  // Reference model: owner 0 none / 1 F / 2 L, last owner, timeout counter, owned cycles
  int m_own, m_last, m_wd, m_run;
  int grants[$];

  bus_arbiter #(.TO_W(8), .TO_LIMIT(LIMIT)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .f_adr_i(f_adr_i), .f_size_i(f_size_i), .f_ack_o(f_ack_o), .f_err_o(f_err_o),
    .l_adr_i(l_adr_i), .l_size_i(l_size_i), .l_we_i(l_we_i), .l_dat_i(l_dat_i),
    .l_ack_o(l_ack_o), .l_err_o(l_err_o),
    .adr_o(adr_o), .size_o(size_o), .we_o(we_o), .dat_o(dat_o),
    .ack_i(ack_i), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic set_in(input logic rst, input logic [1:0] fs, input logic [63:0] fa,
                        input logic [1:0] ls, input logic [63:0] la, input logic we,
                        input logic [15:0] d, input logic ak);
    reset_i = rst; f_size_i = fs; f_adr_i = fa; l_size_i = ls; l_adr_i = la;
    l_we_i = we; l_dat_i = d; ack_i = ak;
  endtask

  task automatic compare_outputs();
    logic [63:0] e_adr;
    logic [1:0]  e_size, e_gnt;
    logic [15:0] e_dat;
    logic        e_we, e_fack, e_lack, e_ferr, e_lerr, tmo;
    e_adr = '0; e_size = 2'b00; e_gnt = 2'b00; e_dat = '0;
    e_we = 1'b0; e_fack = 1'b0; e_lack = 1'b0; e_ferr = 1'b0; e_lerr = 1'b0;
    tmo = (LIMIT != 0) && (m_wd == LIMIT) && !ack_i;
    if (!reset_i && m_own == 1) begin
      e_adr = f_adr_i; e_size = (f_size_i == 2'b11) ? 2'b00 : f_size_i;
      e_fack = ack_i && (f_size_i != 2'b11); e_ferr = tmo; e_gnt = 2'b01;
    end else if (!reset_i && m_own == 2) begin
      e_adr = l_adr_i; e_size = (l_size_i == 2'b11) ? 2'b00 : l_size_i;
      e_we = l_we_i; e_dat = l_dat_i;
      e_lack = ack_i && (l_size_i != 2'b11); e_lerr = tmo; e_gnt = 2'b10;
    end
    check("adr", adr_o, e_adr);
    check("size", 64'(size_o), 64'(e_size));
    check("we", 64'(we_o), 64'(e_we));
    check("dat", 64'(dat_o), 64'(e_dat));
    check("f_ack", 64'(f_ack_o), 64'(e_fack));
    check("l_ack", 64'(l_ack_o), 64'(e_lack));
    check("f_err", 64'(f_err_o), 64'(e_ferr));
    check("l_err", 64'(l_err_o), 64'(e_lerr));
    check("gnt", 64'(gnt_o), 64'(e_gnt));
  endtask

  task automatic model_step();
    bit f_req, l_req, mine, other;
    f_req = (f_size_i != 2'b00);
    l_req = (l_size_i != 2'b00);
    if (reset_i) begin
      m_own = 0; m_last = 1; m_wd = 0; m_run = 0;
    end else if (m_own == 0) begin
      m_wd = 0; m_run = 0;
      if (f_req && l_req) m_own = (m_last == 1) ? 2 : 1;
      else if (l_req) m_own = 2;
      else if (f_req) m_own = 1;
      if (m_own != 0) grants.push_back(m_own);
    end else begin
      mine  = (m_own == 1) ? f_req : l_req;
      other = (m_own == 1) ? l_req : f_req;
      if (!mine) begin
        m_last = m_own;
        m_own  = other ? 3 - m_own : 0;
        m_wd = 0; m_run = 0;
        if (m_own != 0) grants.push_back(m_own);
      end else begin
        m_run++;
        if (ack_i || ((LIMIT != 0) && (m_wd == LIMIT))) m_wd = 0;
        else m_wd++;
      end
    end
  endtask

  // Inputs are stable from just after one rising edge to just after the next
  task automatic cycle();
    @(negedge clk);
    compare_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] fs, ls;
    m_own = 0; m_last = 1; m_wd = 0; m_run = 0;

    // Reset holds everything quiet even with a pending fetch
    set_in(1, 2'b10, 64'hFFFF_FFFF_FFFF_FF00, 0, 0, 0, 0, 0);
    cycle(); cycle();

    // Fetch-only: one dead cycle, then the fetch is on the bus and acked
    set_in(0, 2'b10, 64'hFFFF_FFFF_FFFF_FF00, 0, 0, 0, 0, 0);
    cycle();
    check("fetch_gnt", 64'(gnt_o), 64'(2'b01));
    check("fetch_adr", adr_o, 64'hFFFF_FFFF_FFFF_FF00);
    ack_i = 1'b1;
    cycle();
    check("fetch_ack", 64'({f_ack_o, l_ack_o}), 64'(2'b10));

    // Tie right after reset goes to L, then a gap-free handoff to F
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    set_in(0, 2'b10, 64'h100, 2'b10, 64'h200, 1'b1, 16'h1234, 1'b1);
    cycle();
    check("tie_gnt", 64'(gnt_o), 64'(2'b10));
    check("tie_we_dat", 64'({we_o, dat_o}), 64'({1'b1, 16'h1234}));
    l_size_i = 2'b00;
    cycle();
    check("handoff_gnt", 64'(gnt_o), 64'(2'b01));

    // Atomic hold: L waits out a four-cycle fetch sequence
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    set_in(0, 2'b10, 64'hFF00, 2'b00, 64'h300, 0, 0, 1'b1);
    cycle();
    l_size_i = 2'b10;
    for (int i = 0; i < 4; i++) begin
      f_adr_i = (i < 2) ? 64'hFF00 : 64'hFF02;
      cycle();
      check("hold_gnt", 64'(gnt_o), 64'(2'b01));
    end
    f_size_i = 2'b00;
    cycle();
    check("after_hold_gnt", 64'(gnt_o), 64'(2'b10));

    // Round-robin: both keep requesting, each owner drops after one acked cycle
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    grants.delete();
    for (int i = 0; i < 10; i++) begin
      fs = (m_own == 1 && m_run >= 1) ? 2'b00 : 2'b10;
      ls = (m_own == 2 && m_run >= 1) ? 2'b00 : 2'b10;
      set_in(0, fs, 64'h10, ls, 64'h20, 0, 16'h5, 1'b1);
      cycle();
    end
    check("rr_count", 64'(grants.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++)
      check("rr_order", 64'((i < grants.size()) ? grants[i] : 0), 64'((i % 2 == 0) ? 2 : 1));

    // Timeout on the 5th unacked owned cycle; an ack on the limit cycle suppresses it
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 12; i++) begin
      set_in(0, 2'b00, 0, 2'b10, 64'h40, 0, 16'h7, (i == 10));
      @(negedge clk);
      check("tmo_err", 64'(l_err_o), 64'(i == 5));
      if (i >= 1) check("tmo_gnt", 64'(gnt_o), 64'(2'b10));
      @(posedge clk); #1;
      // Keep the model aligned for the randomized phase
      model_step();
    end

    // Randomized traffic with sticky sizes, sparse acks and occasional reset
    fs = 2'b00; ls = 2'b00;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) fs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ls = 2'($urandom_range(0, 3));
      set_in(($urandom_range(0, 79) == 0), fs, {$urandom, $urandom}, ls,
             {$urandom, $urandom}, 1'($urandom), 16'($urandom),
             ($urandom_range(0, 3) == 0));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
